binary_search_engine: RTL and testbench
=======================================

BINARY_SEARCH_ENGINE -- requirements
Module: binary_search_engine

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 5, meaning the memory address width; depth is 2**ADDR_W.
REQ-002 The module SHALL have parameter DATA_W, default 8, meaning the memory word and target width.
REQ-003 The module SHALL have parameter RD_LAT, default 1, meaning the memory read latency in cycles (range 1..4).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 The module SHALL have port start, input, 1 bit: level request to search.
REQ-007 The module SHALL have port target, input, DATA_W bits: the value to find, sampled with start.
REQ-008 The module SHALL have port descend, input, 1 bit: the memory sort order (0 = ascending, 1 = descending), sampled with start.
REQ-009 The module SHALL have port rd_addr, output, ADDR_W bits: the registered memory read address.
REQ-010 The module SHALL have port rd_data, input, DATA_W bits: the memory read data, valid RD_LAT cycles after rd_addr changes.
REQ-011 The module SHALL have port busy, output, 1 bit: search in progress.
REQ-012 The module SHALL have port done, output, 1 bit: result valid.
REQ-013 The module SHALL have port found, output, 1 bit: target present; it is meaningful only while done=1.
REQ-014 The module SHALL have port result_addr, output, ADDR_W bits: the address of the match, or 0 when the target is not found.
REQ-015 The module SHALL have port probes, output, $clog2(ADDR_W+2) bits: the number of compares performed.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT, COMPARE and DONE.
REQ-017 IDLE: when start=1, the FSM SHALL latch target and descend, set low=0, high=2**ADDR_W-1 and probes=0, then go to ISSUE.
REQ-018 ISSUE: the FSM SHALL register rd_addr=(low+high)>>1, computed at ADDR_W+1 bits with no overflow, then go to WAIT.
REQ-019 WAIT: the FSM SHALL stay in WAIT for exactly RD_LAT cycles, then go to COMPARE.
REQ-020 COMPARE: the FSM SHALL increment probes; if rd_data==target, it SHALL set found=1, set result_addr=mid and go to DONE.
REQ-021 COMPARE, no match: the FSM SHALL treat the target as lying in the lower half when (rd_data>target) XOR descend, and in the upper half otherwise.
REQ-022 Lower half: if mid==low, the FSM SHALL go to DONE with found=0; otherwise it SHALL set high=mid-1 and go to ISSUE.
REQ-023 Upper half: if mid==high, the FSM SHALL go to DONE with found=0; otherwise it SHALL set low=mid+1 and go to ISSUE.
REQ-024 Each probe SHALL take RD_LAT+2 cycles, and done SHALL rise exactly probes*(RD_LAT+2)+1 cycles after the edge that samples start.
REQ-025 The FSM SHALL perform at most ADDR_W+1 probes.
REQ-026 The compare SHALL be unsigned at DATA_W bits.
REQ-027 DONE: done=1 and found, result_addr and probes SHALL hold stable while start=1; when start=0 the FSM SHALL go to IDLE and clear done on the next edge.
REQ-028 busy SHALL be 1 in ISSUE, WAIT and COMPARE, and 0 in IDLE and DONE.
REQ-029 Changes to start, target or descend while busy SHALL be ignored.
REQ-030 Memory contents that are not sorted SHALL still terminate within ADDR_W+1 probes, with an unspecified result.

Reset
REQ-031 When reset=0, the FSM SHALL go to IDLE immediately, regardless of clk.
REQ-032 While reset=0, outputs SHALL be rd_addr=0, busy=0, done=0, found=0, result_addr=0, probes=0; all internal bounds and the latched target/descend SHALL be 0.
REQ-033 A reset asserted mid-search SHALL abort the search with no result reported.
REQ-034 After reset=1, a start that is still held high SHALL begin a new search on the next edge.

Structure
REQ-035 A shared package bsearch_pkg SHALL hold the state enum type and the probe-count width function.
REQ-036 The RAM SHALL be external to this module; instantiation SHALL be left to the top level, where RD_LAT=1 matches ram32x8.
REQ-037 One sub-module, bsearch_ctrl (the FSM), is natural; the bounds/mid datapath SHALL stay in the top of the block.

Verification
REQ-038 With defaults and a model memory, ascending mem[i]=2*i: target=20 -> found=1, result_addr=10, probes=5, done 16 cycles after start.
REQ-039 Same memory, target=21 -> found=0, result_addr=0, probes<=6.
REQ-040 Same memory, boundary targets: target=0 -> addr 0 found; target=62 -> addr 31 found; target=63 -> not found; target=255 -> not found with no address wrap.
REQ-041 descend=1, mem[i]=62-2*i: target=20 -> found=1, result_addr=21.
REQ-042 reset=0 pulsed in WAIT during the search for target=20 -> all outputs 0 at once; with start still 1, the search reruns and gives the REQ-038 result.
REQ-043 Handshake: hold start=1 for 5 cycles after done and change target -> outputs stay stable; drop start -> done=0 on the next edge.

Source files
------------

// File: rtl/bsearch_pkg.sv
// ============================================================
// bsearch_pkg : state encoding and probe-counter sizing for the search engine
// Rev 1.0
// ============================================================
`default_nettype none

package bsearch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // A search never needs more than addr_w+1 compares, so the counter holds 0..addr_w+1
  function automatic int probe_w(input int addr_w);
    return $clog2(addr_w + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsearch_ctrl.sv
// ============================================================
// bsearch_ctrl : sequencing FSM issuing probes and handling the done handshake
// Rev 1.0
// ============================================================
`default_nettype none

module bsearch_ctrl
  import bsearch_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic hit,
  input  logic last,
  output logic load,
  output logic issue,
  output logic compare,
  output logic busy,
  output logic done
);

  localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 3'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = 1'b0;
    load       = 1'b0;
    issue      = 1'b0;
    compare    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue      = 1'b1;
        wait_cnt_d = 3'd0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d = ST_COMPARE;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_COMPARE: begin
        compare = 1'b1;
        state_d = (hit || last) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        // done rises one cycle into DONE and is always shown at least once
        done_d = start || !done_q;
        if (!start && done_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_COMPARE);
  assign done = done_q;

endmodule

`default_nettype wire

// File: rtl/binary_search_engine.sv
// ============================================================
// binary_search_engine : binary search of a target in an external sorted RAM
// Rev 1.0
// ============================================================
`default_nettype none

module binary_search_engine
  import bsearch_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DATA_W-1:0]            target,
  input  logic                         descend,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic [DATA_W-1:0]            rd_data,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [ADDR_W-1:0]            result_addr,
  output logic [probe_w(ADDR_W)-1:0]   probes
);

  localparam int               PROBE_W  = probe_w(ADDR_W);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0]  low_q, low_d;
  logic [ADDR_W-1:0]  high_q, high_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  target_q, target_d;
  logic               descend_q, descend_d;
  logic [PROBE_W-1:0] probes_q, probes_d;
  logic               found_q, found_d;
  logic [ADDR_W-1:0]  result_addr_q, result_addr_d;

  logic               load, issue, compare;
  logic [ADDR_W:0]    bound_sum;
  logic [ADDR_W-1:0]  mid_next;
  logic               hit, go_low, last;

  // The extra sum bit keeps low+high from wrapping when both sit near the top
  assign bound_sum = {1'b0, low_q} + {1'b0, high_q};
  assign mid_next  = ADDR_W'(bound_sum >> 1);

  // rd_addr_q holds mid for the whole probe
  assign hit    = (rd_data == target_q);
  assign go_low = (rd_data > target_q) ^ descend_q;
  assign last   = go_low ? (rd_addr_q == low_q) : (rd_addr_q == high_q);

  bsearch_ctrl #(
    .RD_LAT (RD_LAT)
  ) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .hit     (hit),
    .last    (last),
    .load    (load),
    .issue   (issue),
    .compare (compare),
    .busy    (busy),
    .done    (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      low_q         <= '0;
      high_q        <= '0;
      rd_addr_q     <= '0;
      target_q      <= '0;
      descend_q     <= 1'b0;
      probes_q      <= '0;
      found_q       <= 1'b0;
      result_addr_q <= '0;
    end else begin
      low_q         <= low_d;
      high_q        <= high_d;
      rd_addr_q     <= rd_addr_d;
      target_q      <= target_d;
      descend_q     <= descend_d;
      probes_q      <= probes_d;
      found_q       <= found_d;
      result_addr_q <= result_addr_d;
    end
  end

  always_comb begin
    low_d         = low_q;
    high_d        = high_q;
    rd_addr_d     = rd_addr_q;
    target_d      = target_q;
    descend_d     = descend_q;
    probes_d      = probes_q;
    found_d       = found_q;
    result_addr_d = result_addr_q;
    if (load) begin
      target_d      = target;
      descend_d     = descend;
      low_d         = '0;
      high_d        = '1;
      probes_d      = '0;
      found_d       = 1'b0;
      result_addr_d = '0;
    end
    if (issue) begin
      rd_addr_d = mid_next;
    end
    if (compare) begin
      probes_d = probes_q + PROBE_W'(1);
      if (hit) begin
        found_d       = 1'b1;
        result_addr_d = rd_addr_q;
      end else if (!last) begin
        // last guards both updates, so mid-1 and mid+1 cannot wrap
        if (go_low) begin
          high_d = rd_addr_q - ADDR_ONE;
        end else begin
          low_d = rd_addr_q + ADDR_ONE;
        end
      end
    end
  end

  assign rd_addr     = rd_addr_q;
  assign found       = found_q;
  assign result_addr = result_addr_q;
  assign probes      = probes_q;

endmodule

`default_nettype wire

// File: tb/tb_binary_search_engine.sv
// ============================================================
// tb_binary_search_engine : directed checks of the search engine with a model RAM
// Rev 1.0
// ============================================================
`default_nettype none

module tb_binary_search_engine;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic              start   = 1'b0;
  logic              descend = 1'b0;
  logic [DATA_W-1:0] target  = '0;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] result_addr;
  logic              busy, done, found;
  logic [2:0]        probes;

  logic [DATA_W-1:0] mem [32];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // One-cycle synchronous read model
  always @(posedge clk) rd_data <= mem[rd_addr];

  binary_search_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .target      (target),
    .descend     (descend),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .result_addr (result_addr),
    .probes      (probes)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic fill_ascending();
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
  endtask

  task automatic fill_descending();
    for (int i = 0; i < 32; i++) mem[i] = 8'(62 - 2 * i);
  endtask

  // Start must already be high; the next posedge samples it
  task automatic wait_result(input string tag, input logic exp_found,
                             input int exp_addr, input int exp_probes);
    int  n;
    bit  seen;
    @(posedge clk);
    #1;
    check({tag, " busy_after_start"}, busy, 1);
    // inputs moving while busy must not disturb the search
    target  = ~target;
    descend = ~descend;
    seen = 1'b0;
    n    = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        n    = i;
      end
    end
    check({tag, " done_latency"}, n, exp_probes * 3 + 1);
    check({tag, " found"}, found, exp_found);
    check({tag, " result_addr"}, result_addr, exp_addr);
    check({tag, " probes"}, probes, exp_probes);
    check({tag, " busy_in_done"}, busy, 0);
  endtask

  task automatic run_search(input string tag, input logic [7:0] tgt, input logic desc,
                            input logic exp_found, input int exp_addr, input int exp_probes);
    @(negedge clk);
    target  = tgt;
    descend = desc;
    start   = 1'b1;
    wait_result(tag, exp_found, exp_addr, exp_probes);
  endtask

  task automatic finish_search(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " done_clear"}, done, 0);
  endtask

  initial begin
    fill_ascending();
    #1 reset = 1'b0;
    #10;
    check("rst rd_addr", rd_addr, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst found", found, 0);
    check("rst result_addr", result_addr, 0);
    check("rst probes", probes, 0);
    @(negedge clk);
    reset = 1'b1;

    run_search("asc20", 8'd20, 1'b0, 1'b1, 10, 5);
    finish_search("asc20");
    run_search("asc21", 8'd21, 1'b0, 1'b0, 0, 5);
    finish_search("asc21");
    run_search("asc0", 8'd0, 1'b0, 1'b1, 0, 5);
    finish_search("asc0");
    run_search("asc62", 8'd62, 1'b0, 1'b1, 31, 6);
    finish_search("asc62");
    run_search("asc63", 8'd63, 1'b0, 1'b0, 0, 6);
    finish_search("asc63");
    run_search("asc255", 8'd255, 1'b0, 1'b0, 0, 6);
    finish_search("asc255");

    fill_descending();
    run_search("desc20", 8'd20, 1'b1, 1'b1, 21, 4);
    finish_search("desc20");

    // Reset pulse while waiting on the first read
    fill_ascending();
    @(negedge clk);
    target  = 8'd20;
    descend = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid busy_in_wait", busy, 1);
    check("mid rd_addr_first", rd_addr, 15);
    reset = 1'b0;
    #1;
    check("mid_rst rd_addr", rd_addr, 0);
    check("mid_rst busy", busy, 0);
    check("mid_rst done", done, 0);
    check("mid_rst found", found, 0);
    check("mid_rst result_addr", result_addr, 0);
    check("mid_rst probes", probes, 0);
    @(negedge clk);
    target = 8'd20;
    reset  = 1'b1;
    wait_result("rerun", 1'b1, 10, 5);

    // Hold start in DONE while target changes
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      target = 8'(7 * k + 1);
      @(posedge clk);
      #1;
      check("hold done", done, 1);
      check("hold found", found, 1);
      check("hold result_addr", result_addr, 10);
      check("hold probes", probes, 5);
    end
    finish_search("hold");
    check("idle busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
